seg_compare_loader: RTL and testbench

Configuration controller for the seven-segment seconds counter: collects a 24-bit compare value from user GPIO pads as six 4-bit nibbles framed by a pad handshake. It validates the frame and drives the counter's compare_in/update_compare pair with a single one-cycle commit pulse. It sits in the user project between io_in and the seven-segment counter instance.

---
 rtl/seg_compare_loader.sv | 192 +++++++++++++++++++
 tb/tb_seg_compare_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg_compare_loader.sv
// Loads a 24-bit compare value for the seven-segment seconds counter from GPIO pads,
// framed by pad_frame, one nibble per pad_strobe rise; commits with a single pulse.
module seg_compare_loader #(
  parameter int unsigned               DATA_W      = 24,
  parameter int unsigned               NIBBLES     = 6,
  parameter logic [DATA_W-1:0]         DEFAULT_CMP = 24'h000100,
  parameter int unsigned               TIMEOUT_CYC = 65535
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              pad_frame,
  input  logic              pad_strobe,
  input  logic [3:0]        pad_nibble,
  output logic [DATA_W-1:0] compare_in,
  output logic              update_compare,
  output logic              busy,
  output logic              load_error,
  output logic [2:0]        nibble_count
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_WAIT_END = 3'd2,
    ST_COMMIT   = 3'd3,
    ST_DRAIN    = 3'd4
  } state_t;

  localparam logic [2:0]  LAST_NIB = 3'(NIBBLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [5:0]        sync1_r, sync2_r;
  logic [1:0]        sync_ok_r;
  logic              frame_prev_r, strobe_prev_r;
  logic              frame_s, strobe_s, frame_rise_s, frame_fall_s, strobe_rise_s;
  logic [3:0]        nibble_s;
  state_t            state_r, state_nx;
  logic [DATA_W-1:0] shadow_r, shadow_nx, shifted_s, cmp_r;
  logic [2:0]        count_r, count_nx;
  logic [15:0]       tmo_r, tmo_nx;
  logic              err_r, err_nx, upd_r, busy_r, commit_s, err_set_s;

  // Pad synchronizer and edge-detect history; history stays at 1 until the sync pipe is filled
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_r       <= 6'd0;
      sync2_r       <= 6'd0;
      sync_ok_r     <= 2'b00;
      frame_prev_r  <= 1'b1;
      strobe_prev_r <= 1'b1;
    end else begin
      sync1_r   <= {pad_frame, pad_strobe, pad_nibble};
      sync2_r   <= sync1_r;
      sync_ok_r <= {sync_ok_r[0], 1'b1};
      if (sync_ok_r[1]) begin
        frame_prev_r  <= sync2_r[5];
        strobe_prev_r <= sync2_r[4];
      end else begin
        frame_prev_r  <= frame_prev_r;
        strobe_prev_r <= strobe_prev_r;
      end
    end
  end

  assign frame_s       = sync2_r[5];
  assign strobe_s      = sync2_r[4];
  assign nibble_s      = sync2_r[3:0];
  assign frame_rise_s  = frame_s & ~frame_prev_r;
  assign frame_fall_s  = ~frame_s & frame_prev_r & sync_ok_r[1];
  assign strobe_rise_s = strobe_s & ~strobe_prev_r;
  assign shifted_s     = {shadow_r[DATA_W-5:0], nibble_s};

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic; a final strobe and frame fall in one cycle is judged on the updated frame
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_rise_s) state_nx = ST_COLLECT;
        else              state_nx = ST_IDLE;
      end
      ST_COLLECT: begin
        if (strobe_rise_s && (count_r == LAST_NIB)) begin
          if (frame_fall_s) begin
            if (shifted_s != {DATA_W{1'b0}}) state_nx = ST_COMMIT;
            else                             state_nx = ST_IDLE;
          end else begin
            state_nx = ST_WAIT_END;
          end
        end else if (frame_fall_s) begin
          state_nx = ST_IDLE;
        end else if (!strobe_rise_s && (tmo_r == TMO_LAST)) begin
          state_nx = ST_DRAIN;
        end else begin
          state_nx = ST_COLLECT;
        end
      end
      ST_WAIT_END: begin
        if (frame_fall_s) begin
          if (shadow_r != {DATA_W{1'b0}}) state_nx = ST_COMMIT;
          else                            state_nx = ST_IDLE;
        end else if (strobe_rise_s) begin
          state_nx = ST_DRAIN;
        end else begin
          state_nx = ST_WAIT_END;
        end
      end
      ST_COMMIT: state_nx = ST_IDLE;
      ST_DRAIN: begin
        if (!frame_s) state_nx = ST_IDLE;
        else          state_nx = ST_DRAIN;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath/output next values; any exit from a live frame other than COMMIT is an error
  always_comb begin
    shadow_nx = shadow_r;
    count_nx  = count_r;
    tmo_nx    = tmo_r;
    err_nx    = err_r;
    commit_s  = (state_nx == ST_COMMIT);
    err_set_s = ((state_r == ST_COLLECT) || (state_r == ST_WAIT_END)) &&
                ((state_nx == ST_IDLE) || (state_nx == ST_DRAIN));
    case (state_r)
      ST_IDLE: begin
        if (frame_rise_s) begin
          shadow_nx = {DATA_W{1'b0}};
          count_nx  = 3'd0;
          tmo_nx    = 16'd0;
          err_nx    = 1'b0;
        end else begin
          shadow_nx = shadow_r;
        end
      end
      ST_COLLECT: begin
        if (strobe_rise_s) begin
          shadow_nx = shifted_s;
          count_nx  = count_r + 3'd1;
          tmo_nx    = 16'd0;
        end else begin
          tmo_nx    = tmo_r + 16'd1;
        end
      end
      default: begin
        shadow_nx = shadow_r;
      end
    endcase
    if (err_set_s) begin
      err_nx = 1'b1;
    end else begin
      err_nx = err_nx;
    end
  end

  // Datapath and output registers; compare_in and update_compare move on the same edge
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      shadow_r <= {DATA_W{1'b0}};
      count_r  <= 3'd0;
      tmo_r    <= 16'd0;
      err_r    <= 1'b0;
      cmp_r    <= DEFAULT_CMP;
      upd_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      shadow_r <= shadow_nx;
      count_r  <= count_nx;
      tmo_r    <= tmo_nx;
      err_r    <= err_nx;
      cmp_r    <= commit_s ? shadow_nx : cmp_r;
      upd_r    <= commit_s;
      busy_r   <= (state_nx != ST_IDLE);
    end
  end

  assign compare_in     = cmp_r;
  assign update_compare = upd_r;
  assign busy           = busy_r;
  assign load_error     = err_r;
  assign nibble_count   = count_r;

endmodule

// File: tb/tb_seg_compare_loader.sv
// Directed bench for seg_compare_loader: table of whole frames plus hand-written
// timeout, mid-frame reset and coincident last-strobe/frame-fall sequences.
module tb_seg_compare_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pad_frame = 1'b0;
  logic        pad_strobe = 1'b0;
  logic [3:0]  pad_nibble = 4'h0;
  logic [23:0] compare_in;
  logic        update_compare, busy, load_error;
  logic [2:0]  nibble_count;

  int          n_chk = 0;
  int          n_fail = 0;
  int          pulses = 0;
  logic [23:0] pulse_cmp = 24'h0;

  typedef struct {
    logic [27:0] nibs;   // up to 7 nibbles, first-sent in the top nibble
    int          n;
    logic        err_pre;
    int          npulse;
    logic [23:0] cmp;
    logic        err;
    logic [2:0]  cnt;
  } vec_t;

  always #5 clk = ~clk;

  seg_compare_loader #(.TIMEOUT_CYC(64)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .pad_frame      (pad_frame),
    .pad_strobe     (pad_strobe),
    .pad_nibble     (pad_nibble),
    .compare_in     (compare_in),
    .update_compare (update_compare),
    .busy           (busy),
    .load_error     (load_error),
    .nibble_count   (nibble_count)
  );

  // Count commit pulse cycles and remember the value presented with them
  always @(negedge clk) begin
    if (update_compare) begin
      pulses    <= pulses + 1;
      pulse_cmp <= compare_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_nib(input logic [3:0] nib);
    pad_nibble = nib;
    wait_neg(4);
    pad_strobe = 1'b1;
    wait_neg(4);
    pad_strobe = 1'b0;
    wait_neg(4);
  endtask

  initial begin
    vec_t        vt[5];
    logic [27:0] nb;
    int          p0;

    vt[0] = '{nibs: 28'h1234000, n: 4, err_pre: 1'b0, npulse: 0, cmp: 24'h000100, err: 1'b1, cnt: 3'd4};
    vt[1] = '{nibs: 28'h0003E80, n: 6, err_pre: 1'b0, npulse: 1, cmp: 24'h0003E8, err: 1'b0, cnt: 3'd6};
    vt[2] = '{nibs: 28'h1234567, n: 7, err_pre: 1'b1, npulse: 0, cmp: 24'h0003E8, err: 1'b1, cnt: 3'd6};
    vt[3] = '{nibs: 28'h0010000, n: 6, err_pre: 1'b0, npulse: 1, cmp: 24'h001000, err: 1'b0, cnt: 3'd6};
    vt[4] = '{nibs: 28'h0000000, n: 6, err_pre: 1'b0, npulse: 0, cmp: 24'h001000, err: 1'b1, cnt: 3'd6};

    wait_neg(3);
    rst = 1'b0;
    wait_neg(4);
    chk("rst compare_in", 32'(compare_in), 32'h000100);
    chk("rst update", 32'(update_compare), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst load_error", 32'(load_error), 32'd0);
    chk("rst nibble_count", 32'(nibble_count), 32'd0);
    chk("rst no pulse", 32'(pulses), 32'd0);

    for (int i = 0; i < 5; i++) begin
      p0 = pulses;
      nb = vt[i].nibs;
      pad_frame = 1'b1;
      wait_neg(4);
      for (int k = 0; k < vt[i].n; k++) begin
        send_nib(nb[27-4*k -: 4]);
      end
      chk($sformatf("v%0d err before fall", i), 32'(load_error), 32'(vt[i].err_pre));
      chk($sformatf("v%0d busy in frame", i), 32'(busy), 32'd1);
      pad_frame = 1'b0;
      wait_neg(8);
      chk($sformatf("v%0d pulses", i), 32'(pulses - p0), 32'(vt[i].npulse));
      chk($sformatf("v%0d compare_in", i), 32'(compare_in), 32'(vt[i].cmp));
      chk($sformatf("v%0d load_error", i), 32'(load_error), 32'(vt[i].err));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d nibble_count", i), 32'(nibble_count), 32'(vt[i].cnt));
      if (vt[i].npulse == 1) begin
        chk($sformatf("v%0d cmp at pulse", i), 32'(pulse_cmp), 32'(vt[i].cmp));
      end else begin
        chk($sformatf("v%0d update low", i), 32'(update_compare), 32'd0);
      end
    end

    // Timeout: error lands 64 clocks after the second strobe is detected
    p0 = pulses;
    pad_frame = 1'b1;
    wait_neg(4);
    send_nib(4'h5);
    pad_nibble = 4'h6;
    wait_neg(4);
    pad_strobe = 1'b1;
    wait_neg(66);
    chk("tmo not yet", 32'(load_error), 32'd0);
    chk("tmo count", 32'(nibble_count), 32'd2);
    wait_neg(1);
    chk("tmo fired", 32'(load_error), 32'd1);
    chk("tmo busy", 32'(busy), 32'd1);
    pad_strobe = 1'b0;
    wait_neg(4);
    send_nib(4'h7);
    chk("drain ignores strobe", 32'(nibble_count), 32'd2);
    chk("drain busy", 32'(busy), 32'd1);
    pad_frame = 1'b0;
    wait_neg(8);
    chk("drain exit busy", 32'(busy), 32'd0);
    chk("drain err sticky", 32'(load_error), 32'd1);
    chk("drain no pulse", 32'(pulses - p0), 32'd0);
    chk("drain compare_in", 32'(compare_in), 32'h001000);

    // Reset in mid-frame with frame held high across release
    pad_frame = 1'b1;
    wait_neg(4);
    send_nib(4'h1);
    send_nib(4'h2);
    send_nib(4'h3);
    chk("pre-rst count", 32'(nibble_count), 32'd3);
    rst = 1'b1;
    wait_neg(2);
    chk("mid rst compare_in", 32'(compare_in), 32'h000100);
    chk("mid rst update", 32'(update_compare), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst load_error", 32'(load_error), 32'd0);
    chk("mid rst count", 32'(nibble_count), 32'd0);
    rst = 1'b0;
    wait_neg(10);
    chk("post rst no frame", 32'(busy), 32'd0);
    chk("post rst count", 32'(nibble_count), 32'd0);

    // New frame whose sixth strobe coincides with the frame fall
    pad_frame = 1'b0;
    wait_neg(6);
    p0 = pulses;
    pad_frame = 1'b1;
    wait_neg(4);
    send_nib(4'h0);
    send_nib(4'h0);
    send_nib(4'h0);
    send_nib(4'h0);
    send_nib(4'h4);
    pad_nibble = 4'h2;
    wait_neg(4);
    pad_strobe = 1'b1;
    pad_frame  = 1'b0;
    wait_neg(8);
    pad_strobe = 1'b0;
    wait_neg(4);
    chk("coinc pulses", 32'(pulses - p0), 32'd1);
    chk("coinc compare_in", 32'(compare_in), 32'h000042);
    chk("coinc cmp at pulse", 32'(pulse_cmp), 32'h000042);
    chk("coinc load_error", 32'(load_error), 32'd0);
    chk("coinc busy", 32'(busy), 32'd0);
    chk("coinc count", 32'(nibble_count), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
